pic_cmd_master: RTL and testbench

//  CPU-side initiator for the 8259-style PIC data-bus buffer and read/write logic. Drives the active-low CS/RD/WR, A0 and the
//  tri-state D bus. Runs the ICW1..ICW4 initialisation sequence, then issues OCW writes and status reads on request.

---
 rtl/pic_pkg.sv | 35 +++
 rtl/pic_bus_timer.sv | 23 ++
 rtl/pic_cmd_master.sv | 193 +++++++++++++++++++
 tb/tb_pic_cmd_master.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared states, ICW/OCW bit positions and init-sequence helper for the PIC master
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_GAP    = 3'd4
  } pic_state_t;

  localparam int IC4       = 0;
  localparam int SNGL      = 1;
  localparam int ICW1_FLAG = 4;
  localparam int OCW_BIT3  = 3;
  localparam int OCW_BIT4  = 4;
  localparam int ICW_COUNT = 4;

  // Returns {more, next_index}: which ICW follows idx given the IC4/SNGL bits of ICW1
  function automatic logic [2:0] next_icw(input logic [1:0] idx, input logic [7:0] icw1);
    logic [2:0] r;
    r = 3'b000;
    case (idx)
      2'd0: r = {1'b1, 2'd1};
      2'd1: begin
        if (!icw1[SNGL])    r = {1'b1, 2'd2};
        else if (icw1[IC4]) r = {1'b1, 2'd3};
      end
      2'd2: if (icw1[IC4]) r = {1'b1, 2'd3};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pic_bus_timer.sv
// rtl/pic_bus_timer.sv - loadable down-counter timing each bus phase
module pic_bus_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load phase length minus one on phase entry, then count down and park at zero
  always_ff @(posedge clk) begin
    if (reset)             cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pic_cmd_master.sv
// rtl/pic_cmd_master.sv - 8259 bus initiator: ICW init sequence, OCW writes, status reads (PIC_MASTER_READBACK_EN enables reads)
module pic_cmd_master
  import pic_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       init_done,
  inout  wire  [7:0] D,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       A0
);

  localparam logic [7:0] SETUP_LD   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD  = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD    = 8'(HOLD_CYC - 1);
  localparam logic [7:0] ICW1_FORCE = 8'(1 << ICW1_FLAG);

  pic_state_t state, state_nxt;
  logic       tmr_load, tmr_done;
  logic [7:0] tmr_val;
  logic [7:0] icw_q [ICW_COUNT];
  logic [1:0] icw_idx;
  logic [2:0] nxt_icw;
  logic       init_active, more_icw;
  logic       cur_rd, cur_a0;
  logic [7:0] cur_data;
  logic       hs, start_cmd, drv_en;

  assign cmd_ready = (state == ST_IDLE) && init_done && !init_start;
  assign hs        = cmd_valid && cmd_ready;
`ifdef PIC_MASTER_READBACK_EN
  assign start_cmd = hs;
`else
  assign start_cmd = hs && !cmd_rd;
`endif
  assign nxt_icw   = next_icw(icw_idx, icw_q[0]);
  assign more_icw  = init_active && nxt_icw[2];
  assign D         = drv_en ? cur_data : 8'bz;

  pic_bus_timer #(.W(8)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, phase-timer loads and bus pin decode
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    CS        = 1'b1;
    RD        = 1'b1;
    WR        = 1'b1;
    A0        = 1'b0;
    drv_en    = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (init_start || start_cmd) begin
          state_nxt = ST_SETUP;
          tmr_load  = 1'b1;
          tmr_val   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_nxt = ST_STROBE;
          tmr_load  = 1'b1;
          tmr_val   = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (tmr_done) begin
          state_nxt = ST_HOLD;
          tmr_load  = 1'b1;
          tmr_val   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          state_nxt = ST_GAP;
          tmr_load  = 1'b1;
        end
      end
      ST_GAP: begin
        if (more_icw) begin
          state_nxt = ST_SETUP;
          tmr_load  = 1'b1;
          tmr_val   = SETUP_LD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state == ST_SETUP || state == ST_STROBE || state == ST_HOLD) begin
      CS     = 1'b0;
      A0     = cur_a0;
      drv_en = !cur_rd;
    end
    if (state == ST_STROBE) begin
`ifdef PIC_MASTER_READBACK_EN
      RD = !cur_rd;
`endif
      WR = cur_rd;
    end
  end

  // Capture init words / command fields and step through the ICW sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ICW_COUNT; i++) icw_q[i] <= '0;
      icw_idx     <= '0;
      init_active <= 1'b0;
      init_done   <= 1'b0;
      cur_rd      <= 1'b0;
      cur_a0      <= 1'b0;
      cur_data    <= '0;
    end else if (state == ST_IDLE && init_start) begin
      icw_q[0]    <= icw1;
      icw_q[1]    <= icw2;
      icw_q[2]    <= icw3;
      icw_q[3]    <= icw4;
      icw_idx     <= 2'd0;
      init_active <= 1'b1;
      init_done   <= 1'b0;
      cur_rd      <= 1'b0;
      cur_a0      <= 1'b0;
      cur_data    <= icw1 | ICW1_FORCE;
    end else if (start_cmd) begin
      cur_rd   <= cmd_rd;
      cur_a0   <= cmd_a0;
      cur_data <= cmd_data;
    end else if (state == ST_GAP && init_active) begin
      if (nxt_icw[2]) begin
        icw_idx  <= nxt_icw[1:0];
        cur_a0   <= 1'b1;
        cur_data <= icw_q[nxt_icw[1:0]];
      end else begin
        init_active <= 1'b0;
        init_done   <= 1'b1;
      end
    end
  end

`ifdef PIC_MASTER_READBACK_EN
  logic [7:0] rd_smp;

  // Sample D on the last strobe cycle, publish it as the access enters GAP
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_smp   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (state == ST_STROBE && tmr_done && cur_rd) rd_smp <= D;
      rd_valid <= (state == ST_HOLD) && tmr_done && cur_rd;
      if (state == ST_HOLD && tmr_done && cur_rd) rd_data <= rd_smp;
    end
  end
`else
  assign rd_data  = 8'h00;
  assign rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pic_cmd_master.sv
// tb/tb_pic_cmd_master.sv - directed table-driven bench for pic_cmd_master
module tb_pic_cmd_master;
  import pic_pkg::*;

`ifdef PIC_MASTER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int K_OTHER = 0, K_ICW1 = 1, K_OCW2 = 2, K_OCW3 = 3;

  logic       clk = 1'b0, reset = 1'b1, init_start = 1'b0;
  logic [7:0] icw1 = '0, icw2 = '0, icw3 = '0, icw4 = '0;
  logic       cmd_valid = 1'b0, cmd_rd = 1'b0, cmd_a0 = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, rd_valid, busy, init_done, CS, RD, WR, A0;
  logic [7:0] rd_data;
  wire  [7:0] D;
  logic [7:0] resp_data = 8'h5A;

  int total = 0, bad = 0;

  pic_cmd_master dut (
    .clk(clk), .reset(reset), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd), .cmd_a0(cmd_a0),
    .cmd_data(cmd_data), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .init_done(init_done), .D(D), .CS(CS), .RD(RD), .WR(WR), .A0(A0)
  );

  // PIC responder: drives status byte while selected and read-strobed
  assign D = (!CS && !RD) ? resp_data : 8'bz;

  always #5 clk = ~clk;

  function automatic int decode(input logic a0, input logic [7:0] d);
    if (a0) return K_OTHER;
    if (d[ICW1_FLAG]) return K_ICW1;
    if (d[OCW_BIT3]) return K_OCW3;
    return K_OCW2;
  endfunction

  // Bus monitor: logs each write strobe and counts RD-low / rd_valid cycles
  int         n_wr = 0, rd_low = 0, rdv_cnt = 0, cur_len = 0;
  logic [7:0] wr_d [64];
  logic       wr_a0 [64];
  int         wr_len [64];
  int         wr_kind [64];
  logic       wr_prev = 1'b1;
  always @(negedge clk) begin
    if (!RD) rd_low++;
    if (rd_valid) rdv_cnt++;
    if (!WR && wr_prev) begin
      if (n_wr < 64) begin
        wr_d[n_wr]    = D;
        wr_a0[n_wr]   = A0;
        wr_kind[n_wr] = decode(A0, D);
      end
      cur_len = 1;
    end else if (!WR) begin
      cur_len++;
    end
    if (WR && !wr_prev) begin
      if (n_wr < 64) wr_len[n_wr] = cur_len;
      n_wr++;
    end
    wr_prev = WR;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic run_init(input logic [7:0] w1, w2, w3, w4, input logic with_cmd, output int cyc);
    @(negedge clk);
    init_start = 1'b1;
    icw1 = w1; icw2 = w2; icw3 = w3; icw4 = w4;
    if (with_cmd) begin
      cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'hFF;
      #1;
      chk("ready_vs_init", cmd_ready, 0);
    end
    @(negedge clk);
    init_start = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    icw1 = '0; icw2 = '0; icw3 = '0; icw4 = '0;
    cyc = 1;
    while (!init_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("init_done_reached", init_done, 1);
    cyc = cyc - 1;
  endtask

  typedef struct {
    logic [7:0]      i1, i2, i3, i4;
    int              n;
    logic [3:0][7:0] d;
    logic [3:0]      a0;
    int              cyc;
  } init_vec_t;

  typedef struct {
    logic       rd;
    logic       a0;
    logic [7:0] data;
    int         busy_cyc;
    int         nwr;
    int         kind;
    int         rdlow;
    int         rdv;
    int         rvpos;
    logic [7:0] rdd;
  } cmd_vec_t;

  init_vec_t iv [4];
  cmd_vec_t  cv [4];

  initial begin
    int cyc, base, brd, brv, c, rvpos, rb_sum, ready_busy;

    iv[0] = '{8'h11, 8'h20, 8'h04, 8'h01, 4, {8'h01, 8'h04, 8'h20, 8'h11}, 4'b1110, 20};
    iv[1] = '{8'h02, 8'h20, 8'hAA, 8'h55, 2, {8'h00, 8'h00, 8'h20, 8'h12}, 4'b0010, 10};
    iv[2] = '{8'h00, 8'h08, 8'h04, 8'h77, 3, {8'h00, 8'h04, 8'h08, 8'h10}, 4'b0110, 15};
    iv[3] = '{8'h03, 8'h40, 8'hEE, 8'h03, 3, {8'h00, 8'h03, 8'h40, 8'h13}, 4'b0110, 15};

    cv[0] = '{1'b0, 1'b0, 8'h20, 5, 1, K_OCW2, 0, 0, 0, 8'h00};
    cv[1] = '{1'b0, 1'b0, 8'h0A, 5, 1, K_OCW3, 0, 0, 0, 8'h00};
    cv[2] = '{1'b1, 1'b0, 8'h00, RB * 5, 0, K_OTHER, RB * 2, RB, RB * 5, RB ? 8'h5A : 8'h00};
    cv[3] = '{1'b0, 1'b1, 8'hFC, 5, 1, K_OTHER, 0, 0, 0, RB ? 8'h5A : 8'h00};

    // T1: reset held three cycles
    repeat (3) @(negedge clk);
    chk("rst_cs", CS, 1);
    chk("rst_rd", RD, 1);
    chk("rst_wr", WR, 1);
    chk("rst_a0", A0, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    reset = 1'b0;

    // T6c: command before init_done produces no bus activity
    base = n_wr; rb_sum = 0; ready_busy = 0;
    cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h20;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rb_sum += busy;
      ready_busy += cmd_ready;
    end
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("preinit_busy", rb_sum, 0);
    chk("preinit_ready", ready_busy, 0);
    chk("preinit_writes", n_wr - base, 0);

    // T2/T3 and variants: init sequences
    for (int i = 0; i < 4; i++) begin
      base = n_wr;
      run_init(iv[i].i1, iv[i].i2, iv[i].i3, iv[i].i4, 1'b0, cyc);
      repeat (2) @(negedge clk);
      chk("init_cycles", cyc, iv[i].cyc);
      chk("init_nwr", n_wr - base, iv[i].n);
      for (int j = 0; j < iv[i].n; j++) begin
        chk("init_d", wr_d[base + j], iv[i].d[j]);
        chk("init_a0", wr_a0[base + j], iv[i].a0[j]);
        chk("init_wr_len", wr_len[base + j], 2);
        chk("init_kind", wr_kind[base + j], (j == 0) ? K_ICW1 : K_OTHER);
      end
      chk("init_idle_ready", cmd_ready, 1);
    end

    // T4/T5: OCW writes and status read
    for (int i = 0; i < 4; i++) begin
      base = n_wr; brd = rd_low; brv = rdv_cnt; rvpos = 0; ready_busy = 0;
      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_rd = cv[i].rd; cmd_a0 = cv[i].a0; cmd_data = cv[i].data;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_data = '0;
      c = 0;
      while (busy && c < 20) begin
        if (rd_valid) rvpos = c + 1;
        ready_busy += cmd_ready;
        c++;
        @(negedge clk);
      end
      chk("cmd_busy_cycles", c, cv[i].busy_cyc);
      chk("cmd_ready_during_busy", ready_busy, 0);
      chk("cmd_ready_after", cmd_ready, 1);
      repeat (2) @(negedge clk);
      chk("cmd_nwr", n_wr - base, cv[i].nwr);
      if (cv[i].nwr == 1) begin
        chk("cmd_a0", wr_a0[base], cv[i].a0);
        chk("cmd_d", wr_d[base], cv[i].data);
        chk("cmd_kind", wr_kind[base], cv[i].kind);
        chk("cmd_wr_len", wr_len[base], 2);
      end
      chk("cmd_rd_low", rd_low - brd, cv[i].rdlow);
      chk("cmd_rd_valid", rdv_cnt - brv, cv[i].rdv);
      chk("cmd_rd_valid_pos", rvpos, cv[i].rvpos);
      chk("cmd_rd_data", rd_data, cv[i].rdd);
    end

    // T6b: init_start together with cmd_valid, init wins
    base = n_wr;
    run_init(8'h02, 8'h20, 8'hAA, 8'h55, 1'b1, cyc);
    repeat (2) @(negedge clk);
    chk("prio_cycles", cyc, 10);
    chk("prio_nwr", n_wr - base, 2);
    chk("prio_d0", wr_d[base], 8'h12);
    chk("prio_a0_0", wr_a0[base], 0);
    chk("prio_d1", wr_d[base + 1], 8'h20);

    // T6a: reset during the ICW2 strobe
    @(negedge clk);
    init_start = 1'b1;
    icw1 = 8'h11; icw2 = 8'h20; icw3 = 8'h04; icw4 = 8'h01;
    @(negedge clk);
    init_start = 1'b0;
    for (int k = 1; k < 7; k++) @(negedge clk);
    chk("icw2_wr_low", WR, 0);
    chk("icw2_a0", A0, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wr", WR, 1);
    chk("abort_cs", CS, 1);
    chk("abort_init_done", init_done, 0);
    chk("abort_busy", busy, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", busy, 0);
    chk("abort_ready", cmd_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
